hazard_detection_unit: RTL and testbench

//  Load-use hazard detector for the 5-stage pipelined RISC-V core, sitting in the ID stage.
//  - Compares the destination register of a load in EX with the source registers of the instruction in ID.
//  - On a match, stalls PC and IF/ID for one cycle and zeroes the controls entering ID/EX (bubble).
//  - Also keeps a registered stall flag and a saturating stall counter for performance monitoring.

---
 rtl/hazard_detection_unit_pkg.sv | 19 +
 rtl/hazard_detection_unit_if.sv | 23 ++
 rtl/hazard_detection_unit_sat_counter.sv | 18 +
 rtl/hazard_detection_unit.sv | 37 +++
 tb/tb_hazard_detection_unit.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/hazard_detection_unit_pkg.sv
// Shared pipeline types and encodings used by the ID-stage hazard logic.
package hazard_detection_unit_pkg;

  typedef logic [4:0] reg_idx_t;

  // Result-source encoding that marks the EX instruction as a load.
  localparam logic [1:0] RES_SRC_MEM = 2'b00;

  // True when a load in EX writes a register that the ID instruction reads.
  function automatic logic load_use_hazard(
    input logic [1:0] res_src,
    input reg_idx_t   rd,
    input reg_idx_t   rs1,
    input reg_idx_t   rs2
  );
    return (res_src == RES_SRC_MEM) && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/hazard_detection_unit_if.sv
// ID-stage hazard bus: EX/ID register indices in, pipeline write enables out.
interface hazard_detection_unit_if;
  import hazard_detection_unit_pkg::*;

  logic [1:0] ID_EX_MemRead;
  reg_idx_t   ID_EX_Rd;
  reg_idx_t   IF_ID_Rs1;
  reg_idx_t   IF_ID_Rs2;
  logic       IF_ID_Write;
  logic       PCWrite;
  logic       ControlEn;

  modport master (
    output ID_EX_MemRead, ID_EX_Rd, IF_ID_Rs1, IF_ID_Rs2,
    input  IF_ID_Write, PCWrite, ControlEn
  );

  modport slave (
    input  ID_EX_MemRead, ID_EX_Rd, IF_ID_Rs1, IF_ID_Rs2,
    output IF_ID_Write, PCWrite, ControlEn
  );

endinterface

// File: rtl/hazard_detection_unit_sat_counter.sv
// Generic saturating up-counter with synchronous active-high clear.
module hazard_detection_unit_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (inc && (count != {W{1'b1}}))
      count <= count + W'(1);
  end

endmodule

// File: rtl/hazard_detection_unit.sv
// Load-use hazard detector: combinational stall/bubble enables plus
// a registered stall flag and saturating stall-cycle counter.
module hazard_detection_unit
  import hazard_detection_unit_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  hazard_detection_unit_if.slave bus,
  output logic                  stall_q,
  output logic [CNT_W-1:0]      stall_count
);

  logic hazard;

  // Enables are not gated by reset: they track the inputs at all times.
  assign hazard = load_use_hazard(bus.ID_EX_MemRead, bus.ID_EX_Rd,
                                  bus.IF_ID_Rs1, bus.IF_ID_Rs2);

  assign bus.IF_ID_Write = ~hazard;
  assign bus.PCWrite     = ~hazard;
  assign bus.ControlEn   = ~hazard;

  always_ff @(posedge clk) begin
    if (rst) stall_q <= 1'b0;
    else     stall_q <= hazard;
  end

  hazard_detection_unit_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hazard),
    .count (stall_count)
  );

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Self-checking bench: directed spec vectors plus randomized traffic against a behavioural model.
module tb_hazard_detection_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_detection_unit_if bus ();
  hazard_detection_unit_if bus2 ();

  logic        stall_q, stall_q2;
  logic [15:0] stall_count;
  logic [1:0]  stall_count2;

  hazard_detection_unit #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .stall_q(stall_q), .stall_count(stall_count));

  hazard_detection_unit #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .stall_q(stall_q2), .stall_count(stall_count2));

  assign bus2.ID_EX_MemRead = bus.ID_EX_MemRead;
  assign bus2.ID_EX_Rd      = bus.ID_EX_Rd;
  assign bus2.IF_ID_Rs1     = bus.IF_ID_Rs1;
  assign bus2.IF_ID_Rs2     = bus.IF_ID_Rs2;

  int pass_cnt = 0;
  int total    = 0;

  // Reference state
  int m_q   = 0;
  int m_c16 = 0;
  int m_c2  = 0;

  function automatic int model_hazard(int mr, int rd, int rs1, int rs2);
    int is_load, reads_rd;
    is_load  = (mr == 0);
    reads_rd = (rd == rs1) || (rd == rs2);
    return (is_load && rd != 0 && reads_rd) ? 1 : 0;
  endfunction

  function automatic int cur_hazard();
    return model_hazard(int'(bus.ID_EX_MemRead), int'(bus.ID_EX_Rd),
                        int'(bus.IF_ID_Rs1), int'(bus.IF_ID_Rs2));
  endfunction

  task automatic drive(input int mr, input int rd, input int rs1, input int rs2);
    bus.ID_EX_MemRead = 2'(mr);
    bus.ID_EX_Rd      = 5'(rd);
    bus.IF_ID_Rs1     = 5'(rs1);
    bus.IF_ID_Rs2     = 5'(rs2);
    #1;
  endtask

  // Advance one clock and update the reference state from what was presented at the edge.
  task automatic step();
    int h, r;
    h = cur_hazard();
    r = rst;
    @(posedge clk);
    if (r) begin
      m_q = 0; m_c16 = 0; m_c2 = 0;
    end else begin
      m_q = h;
      if (h && m_c16 < 65535) m_c16++;
      if (h && m_c2 < 3) m_c2++;
    end
    #1;
  endtask

  task automatic test_reset();
    logic [2:0] en, exp_en;
    rst = 1'b1;
    drive(0, 5, 5, 9);
    step(); step();
    total++;
    if (stall_q !== 1'b0 || stall_count !== 16'd0) $display("FAIL reset_state: q=%0b cnt=%0d expected q=0 cnt=0", stall_q, stall_count);
    else pass_cnt++;
    en = {bus.IF_ID_Write, bus.PCWrite, bus.ControlEn};
    exp_en = 3'b000;
    total++;
    if (en !== exp_en) $display("FAIL reset_enables_hazard: got %b expected %b", en, exp_en);
    else pass_cnt++;
    drive(1, 5, 5, 9);
    en = {bus.IF_ID_Write, bus.PCWrite, bus.ControlEn};
    exp_en = 3'b111;
    total++;
    if (en !== exp_en) $display("FAIL reset_enables_idle: got %b expected %b", en, exp_en);
    else pass_cnt++;
    step();
    rst = 1'b0;
  endtask

  // Apply one vector, check the enables, clock it, check the registered state.
  task automatic test_vector(input string name, input int mr, input int rd, input int rs1, input int rs2,
                             input logic exp_en1);
    logic [2:0] en;
    drive(mr, rd, rs1, rs2);
    en = {bus.IF_ID_Write, bus.PCWrite, bus.ControlEn};
    total++;
    if (en !== {3{exp_en1}} || en !== {3{cur_hazard() == 0}})
      $display("FAIL %s_enables: got %b expected %b", name, en, {3{exp_en1}});
    else pass_cnt++;
    step();
    total++;
    if (stall_q !== 1'(m_q) || stall_count !== 16'(m_c16))
      $display("FAIL %s_regs: q=%0b cnt=%0d expected q=%0d cnt=%0d", name, stall_q, stall_count, m_q, m_c16);
    else pass_cnt++;
  endtask

  task automatic test_directed();
    test_vector("no_hazard_x0", 1, 0, 1, 2, 1'b1);
    test_vector("rs1_match",    0, 5, 5, 10, 1'b0);
    total++;
    if (stall_q !== 1'b1 || stall_count !== 16'd1)
      $display("FAIL rs1_match_count: q=%0b cnt=%0d expected q=1 cnt=1", stall_q, stall_count);
    else pass_cnt++;
    test_vector("rs2_match",    0, 8, 3, 8, 1'b0);
    total++;
    if (stall_count !== 16'd2) $display("FAIL rs2_match_count: got %0d expected 2", stall_count);
    else pass_cnt++;
    test_vector("not_load",     3, 6, 6, 7, 1'b1);
    total++;
    if (stall_count !== 16'd2) $display("FAIL not_load_count: got %0d expected 2", stall_count);
    else pass_cnt++;
    test_vector("no_match",     0, 9, 3, 4, 1'b1);
    test_vector("load_x0",      0, 0, 0, 5, 1'b1);
    test_vector("mr01",         1, 7, 7, 7, 1'b1);
    test_vector("mr10",         2, 7, 7, 7, 1'b1);
    test_vector("both_match",   0, 12, 12, 12, 1'b0);
  endtask

  task automatic test_random();
    logic [2:0] en;
    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(0, 29) == 0);
      drive($urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5));
      en = {bus.IF_ID_Write, bus.PCWrite, bus.ControlEn};
      total++;
      if (en !== {3{cur_hazard() == 0}})
        $display("FAIL rand_enables[%0d]: got %b expected %b", i, en, {3{cur_hazard() == 0}});
      else pass_cnt++;
      step();
      total++;
      if (stall_q !== 1'(m_q) || stall_count !== 16'(m_c16) || stall_count2 !== 2'(m_c2))
        $display("FAIL rand_regs[%0d]: q=%0b cnt=%0d cnt2=%0d expected q=%0d cnt=%0d cnt2=%0d",
                 i, stall_q, stall_count, stall_count2, m_q, m_c16, m_c2);
      else pass_cnt++;
    end
    rst = 1'b0;
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(0, 3, 3, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      total++;
      if (stall_count2 !== 2'(m_c2) || stall_count !== 16'(m_c16))
        $display("FAIL saturation[%0d]: cnt2=%0d cnt=%0d expected cnt2=%0d cnt=%0d",
                 i, stall_count2, stall_count, m_c2, m_c16);
      else pass_cnt++;
    end
    total++;
    if (stall_count2 !== 2'd3) $display("FAIL saturation_hold: got %0d expected 3", stall_count2);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_stall();
    logic [2:0] en;
    drive(0, 4, 1, 4);
    step();
    rst = 1'b1;
    #1;
    en = {bus.IF_ID_Write, bus.PCWrite, bus.ControlEn};
    total++;
    if (en !== 3'b000) $display("FAIL mid_stall_enables: got %b expected 000", en);
    else pass_cnt++;
    step();
    total++;
    if (stall_q !== 1'b0 || stall_count !== 16'd0 || stall_count2 !== 2'd0)
      $display("FAIL mid_stall_reset: q=%0b cnt=%0d cnt2=%0d expected 0 0 0", stall_q, stall_count, stall_count2);
    else pass_cnt++;
    rst = 1'b0;
    step();
    total++;
    if (stall_q !== 1'b1 || stall_count !== 16'd1)
      $display("FAIL after_reset_stall: q=%0b cnt=%0d expected q=1 cnt=1", stall_q, stall_count);
    else pass_cnt++;
    drive(1, 0, 0, 0);
  endtask

  initial begin
    drive(1, 0, 0, 0);
    test_reset();
    test_directed();
    test_random();
    test_saturation();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
